pc_register: RTL and testbench
==============================

// Module: pc_register
// PURPOSE
//   16-bit 6502 program counter: PCL/PCH registers, +1 increment chain, bus
//   loads and relative-branch add with the one-cycle PCH fix-up on page crossing.
//   Sits between the sequencer/address buses and the address output mux.
//   Contains two pc_increment instances (PCL, PCH) whose inputs come from these
//   registers and whose outputs are written back to them.
// PARAMETERS
//   RESET_PC  16'hFFFC  PC value loaded on reset (reset-vector address)
// PORTS
//   clk            in   1   system clock; all state changes on rising edge
//   reset          in   1   synchronous, active-high reset
//   pc_inc         in   1   increment PC by 1 this cycle
//   load_pcl       in   1   PCL <= adl_in
//   load_pch       in   1   PCH <= adh_in
//   adl_in         in   8   low address bus
//   adh_in         in   8   high address bus
//   branch_start   in   1   add signed branch_offset to PCL
//   branch_offset  in   8   two's-complement relative offset
//   pc_out         out  16  {PCH, PCL}, registered
//   pcl_out        out  8   PCL
//   pch_out        out  8   PCH
//   busy           out  1   FIXUP state: PCH correction pending this cycle
// BEHAVIOUR
//   Reset: PC <= RESET_PC, state IDLE, busy 0; overrides everything, incl. FIXUP.
//   Outputs driven straight from registers; changes visible the cycle after the command.
//   States: IDLE, FIXUP. busy = (state == FIXUP).
//   IDLE, per-cycle priority: load > branch > increment.
//   - load_pcl/load_pch (either or both): load the selected byte(s).
//     Unloaded byte holds. pc_inc and branch_start ignored that cycle.
//   - branch_start: PCL <= PCL + offset (mod 256); pc_inc ignored.
//     Crossing: offset[7]=0 and 8-bit carry out -> fix = +1;
//     offset[7]=1 and no carry out -> fix = -1; otherwise no crossing.
//     No crossing: remain IDLE, PCH unchanged.
//     Crossing: -> FIXUP, latch fix direction, PCH unchanged this cycle.
//   - pc_inc: PC <= PC + 1 via PCL then PCH incrementer chain, same cycle.
//     PCL wraps FF->00 and carries into PCH; FFFF -> 0000, no flag.
//   FIXUP (exactly one cycle), then unconditionally -> IDLE:
//   - PCH <= PCH + fix (mod 256; FF+1 -> 00, 00-1 -> FF).
//   - load_pch: adh_in wins, fix discarded. load_pcl: PCL loaded, fix still applied.
//   - pc_inc and branch_start ignored; sequencer does not issue them.
//   No arithmetic flags exported; wrap-around is silent.
// TESTING
//   1 reset 1 cycle -> pc_out=16'hFFFC, busy=0; reset during FIXUP -> FFFC, busy=0 next cycle.
//   2 load_pcl adl=34 + load_pch adh=12 (with pc_inc=1) -> 1234; pc_inc x3 -> 1237.
//   3 PC=12FF pc_inc -> 1300; PC=FFFF pc_inc -> 0000; PC=12FE pc_inc -> 12FF.
//   4 PC=1080 branch +10 -> 1090, busy=0; PC=10F0 branch +20 -> 1010, busy=1,
//     then 1110, busy=0.
//   5 PC=1005 branch F0 (-16) -> 10F5, busy=1, then 0FF5; PC=1085 branch F0 -> 1075, no FIXUP.
//   6 PC=10F0 branch +20, then load_pch adh=40 in FIXUP -> 4010;
//     with load_pcl adl=55 instead -> 1155; branch_start+pc_inc together -> branch only.

Source files
------------

// File: rtl/pc_register_if.sv
// ---------------------------------------------------------------------------
// pc_register_if
//   Bundle of command and result signals between the sequencer and the
//   6502 program-counter block.
//
//   Handshake: there is no valid/ready pair. Every command input is a
//   single-cycle strobe sampled on the rising clock edge. The results
//   (pc_out, pcl_out, pch_out, busy, dbg_state) are register outputs that
//   are valid on every cycle and reflect the commands of the previous cycle.
//
//   Signals
//     pc_inc        seq -> pc   increment PC by one
//     load_pcl      seq -> pc   PCL <= adl_in
//     load_pch      seq -> pc   PCH <= adh_in
//     adl_in[7:0]   seq -> pc   low address bus
//     adh_in[7:0]   seq -> pc   high address bus
//     branch_start  seq -> pc   add signed branch_offset to PCL
//     branch_offset seq -> pc   two's-complement relative offset
//     pc_out[15:0]  pc -> seq   {PCH, PCL}
//     pcl_out[7:0]  pc -> seq   PCL
//     pch_out[7:0]  pc -> seq   PCH
//     busy          pc -> seq   PCH fix-up is pending this cycle
//     dbg_state     pc -> seq   raw FSM state (0 = IDLE, 1 = FIXUP)
// ---------------------------------------------------------------------------
interface pc_register_if;
  logic        pc_inc;
  logic        load_pcl;
  logic        load_pch;
  logic [7:0]  adl_in;
  logic [7:0]  adh_in;
  logic        branch_start;
  logic [7:0]  branch_offset;
  logic [15:0] pc_out;
  logic [7:0]  pcl_out;
  logic [7:0]  pch_out;
  logic        busy;
  logic        dbg_state;

  modport master (
    output pc_inc, load_pcl, load_pch, adl_in, adh_in, branch_start, branch_offset,
    input  pc_out, pcl_out, pch_out, busy, dbg_state
  );

  modport slave (
    input  pc_inc, load_pcl, load_pch, adl_in, adh_in, branch_start, branch_offset,
    output pc_out, pcl_out, pch_out, busy, dbg_state
  );
endinterface

// File: rtl/pc_register.sv
// ---------------------------------------------------------------------------
// pc_register
//   16-bit 6502 program counter. Holds PCL/PCH, increments through a
//   PCL -> PCH incrementer chain, loads either byte from the address buses
//   and performs relative branches on PCL with a one-cycle PCH fix-up when
//   the branch crosses a page.
//
//   Ports
//     clk    in   system clock, all state changes on the rising edge
//     reset  in   synchronous active-high reset, loads RESET_PC
//     bus    slave modport of pc_register_if (commands in, PC out)
//
//   pc_increment is a small 8-bit +1/-1 stepper; one instance serves PCL,
//   the other serves PCH for both the carry chain and the fix-up.
// ---------------------------------------------------------------------------
module pc_increment (
  input  logic [7:0] a_i,
  input  logic       inc_i,
  input  logic       dec_i,
  output logic [7:0] y_o
);
  always_comb begin
    y_o = a_i;
    if (inc_i)      y_o = a_i + 8'd1;
    else if (dec_i) y_o = a_i - 8'd1;
  end
endmodule

module pc_register #(
  parameter logic [15:0] RESET_PC = 16'hFFFC
) (
  input  logic            clk,
  input  logic            reset,
  pc_register_if.slave    bus
);
  typedef enum logic {IDLE = 1'b0, FIXUP = 1'b1} state_t;

  state_t     state_q;
  logic [7:0] pcl_q;
  logic [7:0] pch_q;
  logic       fix_dec_q;   // 1: PCH fix-up is -1, 0: +1

  logic [7:0] pcl_step_d;
  logic [7:0] pch_step_d;
  logic       pch_inc_en;
  logic       pch_dec_en;
  logic [8:0] br_sum_d;
  logic       br_cross_d;

  // In IDLE the PCH stepper is the upper half of the +1 chain (carry out of
  // PCL is "PCL all ones"); in FIXUP it applies the latched page correction.
  assign pch_inc_en = (state_q == IDLE) ? (&pcl_q) : ~fix_dec_q;
  assign pch_dec_en = (state_q == FIXUP) & fix_dec_q;

  pc_increment u_pcl_inc (
    .a_i   (pcl_q),
    .inc_i (1'b1),
    .dec_i (1'b0),
    .y_o   (pcl_step_d)
  );

  pc_increment u_pch_inc (
    .a_i   (pch_q),
    .inc_i (pch_inc_en),
    .dec_i (pch_dec_en),
    .y_o   (pch_step_d)
  );

  // Page crossing: a forward branch that carries out of PCL, or a backward
  // branch (sign-extended offset) that does not carry out.
  assign br_sum_d   = {1'b0, pcl_q} + {1'b0, bus.branch_offset};
  assign br_cross_d = bus.branch_offset[7] ^ br_sum_d[8];

  always_ff @(posedge clk) begin
    if (reset) begin
      pcl_q     <= RESET_PC[7:0];
      pch_q     <= RESET_PC[15:8];
      state_q   <= IDLE;
      fix_dec_q <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          if (bus.load_pcl || bus.load_pch) begin
            if (bus.load_pcl) pcl_q <= bus.adl_in;
            if (bus.load_pch) pch_q <= bus.adh_in;
          end else if (bus.branch_start) begin
            pcl_q <= br_sum_d[7:0];
            if (br_cross_d) begin
              state_q   <= FIXUP;
              fix_dec_q <= bus.branch_offset[7];
            end
          end else if (bus.pc_inc) begin
            pcl_q <= pcl_step_d;
            pch_q <= pch_step_d;
          end
        end
        FIXUP: begin
          if (bus.load_pcl) pcl_q <= bus.adl_in;
          // A bus load of PCH replaces the pending correction.
          pch_q   <= bus.load_pch ? bus.adh_in : pch_step_d;
          state_q <= IDLE;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign bus.pc_out    = {pch_q, pcl_q};
  assign bus.pcl_out   = pcl_q;
  assign bus.pch_out   = pch_q;
  assign bus.busy      = (state_q == FIXUP);
  assign bus.dbg_state = state_q;
endmodule

// File: tb/tb_pc_register.sv
module tb_pc_register;
  logic clk;
  logic reset;

  pc_register_if bus ();

  pc_register #(.RESET_PC(16'hFFFC)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  // ---------------- clock / reset ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // ---------------- scoreboard ----------------
  logic [16:0] exp_q[$];   // {busy, pc}
  string       name_q[$];
  int          chk_cnt  = 0;
  int          pass_cnt = 0;

  // Reference model: PC as a 16-bit number plus a pending page correction.
  logic [15:0] m_pc   = 16'hFFFC;
  int          m_pend = 0;

  task automatic model_step(input logic r, lpl, lph, inc, bs,
                            input logic [7:0] adl, adh, off);
    logic [7:0] pcl;
    logic [7:0] pch;
    int         t;
    pcl = m_pc[7:0];
    pch = m_pc[15:8];
    if (r) begin
      m_pc   = 16'hFFFC;
      m_pend = 0;
      return;
    end
    if (m_pend != 0) begin
      pch    = lph ? adh : 8'(int'(pch) + m_pend);
      pcl    = lpl ? adl : pcl;
      m_pend = 0;
      m_pc   = {pch, pcl};
    end else if (lpl || lph) begin
      if (lpl) pcl = adl;
      if (lph) pch = adh;
      m_pc = {pch, pcl};
    end else if (bs) begin
      t      = int'(pcl) + int'($signed(off));
      m_pc   = {pch, t[7:0]};
      m_pend = (t > 255) ? 1 : ((t < 0) ? -1 : 0);
    end else if (inc) begin
      m_pc = m_pc + 16'd1;
    end
  endtask

  // ---------------- driver ----------------
  task automatic cycle(input logic r, lpl, lph, inc, bs,
                       input logic [7:0] adl, adh, off, input string nm);
    @(negedge clk);
    reset             = r;
    bus.load_pcl      = lpl;
    bus.load_pch      = lph;
    bus.pc_inc        = inc;
    bus.branch_start  = bs;
    bus.adl_in        = adl;
    bus.adh_in        = adh;
    bus.branch_offset = off;
    model_step(r, lpl, lph, inc, bs, adl, adh, off);
    exp_q.push_back({m_pend != 0, m_pc});
    name_q.push_back(nm);
    @(posedge clk);
  endtask

  task automatic set_pc(input logic [15:0] v);
    cycle(1'b0, 1'b1, 1'b1, 1'b0, 1'b0, v[7:0], v[15:8], 8'h00, "load_pc");
  endtask

  task automatic do_inc(input string nm);
    cycle(1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 8'h00, 8'h00, 8'h00, nm);
  endtask

  task automatic do_branch(input logic [7:0] off, input string nm);
    cycle(1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 8'h00, 8'h00, off, nm);
  endtask

  task automatic idle(input string nm);
    cycle(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 8'h00, 8'h00, 8'h00, nm);
  endtask

  // ---------------- monitor ----------------
  always @(posedge clk) begin
    logic [16:0] e;
    string       nm;
    #2;
    if (exp_q.size() > 0) begin
      e  = exp_q.pop_front();
      nm = name_q.pop_front();
      chk_cnt++;
      if ({bus.busy, bus.pc_out} === e) pass_cnt++;
      else $display("FAIL %s: got pc=%h busy=%b, expected pc=%h busy=%b",
                    nm, bus.pc_out, bus.busy, e[15:0], e[16]);
      chk_cnt++;
      if ({bus.dbg_state, bus.pch_out, bus.pcl_out} === e) pass_cnt++;
      else $display("FAIL %s_bytes: got state=%b pch=%h pcl=%h, expected state=%b pch=%h pcl=%h",
                    nm, bus.dbg_state, bus.pch_out, bus.pcl_out, e[16], e[15:8], e[7:0]);
    end
  end

  // ---------------- stimulus ----------------
  initial begin
    reset             = 1'b1;
    bus.pc_inc        = 1'b0;
    bus.load_pcl      = 1'b0;
    bus.load_pch      = 1'b0;
    bus.adl_in        = 8'h00;
    bus.adh_in        = 8'h00;
    bus.branch_start  = 1'b0;
    bus.branch_offset = 8'h00;

    // reset
    cycle(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 8'h00, 8'h00, 8'h00, "reset");
    idle("after_reset");

    // loads win over pc_inc, then plain increments
    cycle(1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 8'h34, 8'h12, 8'h00, "load_1234");
    do_inc("inc_1235");
    do_inc("inc_1236");
    do_inc("inc_1237");
    cycle(1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 8'hAA, 8'h00, 8'h10, "load_pcl_only");
    cycle(1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 8'h00, 8'h77, 8'h00, "load_pch_only");

    // increment carry chain
    set_pc(16'h12FF); do_inc("inc_12ff");
    set_pc(16'hFFFF); do_inc("inc_ffff");
    set_pc(16'h12FE); do_inc("inc_12fe");

    // forward branches
    set_pc(16'h1080); do_branch(8'h10, "br_fwd_same_page");
    set_pc(16'h10F0); do_branch(8'h20, "br_fwd_cross"); idle("fixup_fwd");
    set_pc(16'hFFF0); do_branch(8'h20, "br_fwd_cross_ff"); idle("fixup_ff_wrap");

    // backward branches
    set_pc(16'h1005); do_branch(8'hF0, "br_back_cross"); idle("fixup_back");
    set_pc(16'h1085); do_branch(8'hF0, "br_back_same_page");
    set_pc(16'h0010); do_branch(8'h80, "br_back_cross_00"); idle("fixup_00_wrap");

    // loads during FIXUP
    set_pc(16'h10F0); do_branch(8'h20, "br_pre_loadpch");
    cycle(1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 8'h00, 8'h40, 8'h00, "fixup_load_pch");
    set_pc(16'h10F0); do_branch(8'h20, "br_pre_loadpcl");
    cycle(1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 8'h55, 8'h00, 8'h00, "fixup_load_pcl");

    // branch has priority over increment
    set_pc(16'h2040);
    cycle(1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 8'h00, 8'h00, 8'h05, "br_over_inc");

    // reset in FIXUP
    set_pc(16'h10F0); do_branch(8'h20, "br_pre_reset");
    cycle(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 8'h00, 8'h00, 8'h00, "reset_in_fixup");
    idle("after_reset_fixup");

    // randomized traffic
    for (int i = 0; i < 400; i++) begin
      logic       r, lpl, lph, inc, bs;
      logic [7:0] adl, adh, off;
      r   = ($urandom_range(0, 49) == 0);
      lpl = ($urandom_range(0, 5) == 0);
      lph = ($urandom_range(0, 5) == 0);
      inc = ($urandom_range(0, 1) == 0);
      bs  = ($urandom_range(0, 2) == 0);
      adl = 8'($urandom_range(0, 255));
      adh = 8'($urandom_range(0, 255));
      off = 8'($urandom_range(0, 255));
      cycle(r, lpl, lph, inc, bs, adl, adh, off, "random");
    end

    // drain: the monitor pops within a few ns of the last edge
    #5;
    chk_cnt++;
    if (exp_q.size() == 0) pass_cnt++;
    else $display("FAIL drain: got %0d pending entries, expected 0", exp_q.size());

    $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
    $finish;
  end
endmodule
